mux21_stream_arb: RTL

//   Sequential front end for the 2:1 mux datapath. Merges two valid/ready

---
 rtl/mux21_stream_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux21_stream_arb.sv
// mux21_stream_arb: merges two valid/ready packet streams (i0, i1) into one
// registered output stream and drives the downstream 2:1 mux select.
// Round-robin arbitration is done between packets; once a beat without
// last is accepted, the grant stays on that source until its last beat.
// The output is a single-entry register, so input data never reaches the
// output combinationally.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i0_data/last/valid, i0_ready   source 0 stream
//   i1_data/last/valid, i1_ready   source 1 stream
//   y_data/last/valid, y_ready     registered output stream
//   sel                            source of the beat held in y_data (0=i0, 1=i1)
module mux21_stream_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_last,
  input  logic             i0_valid,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_last,
  input  logic             i1_valid,
  output logic             i1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;
  logic             y_valid_q, y_valid_d;
  logic             sel_q, sel_d;

  logic load, g0, g1, acc0, acc1;

  // Output register can take a beat: empty, or its beat leaves this edge.
  assign load = ~y_valid_q | y_ready;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state_q)
      StLock0: g0 = 1'b1;
      StLock1: g1 = 1'b1;
      default: begin
        // prio names the source that wins a tie.
        g0 = i0_valid & (~i1_valid | ~prio_q);
        g1 = i1_valid & (~i0_valid | prio_q);
      end
    endcase
  end

  // Sources see no ready while the block is held in reset, so nothing is
  // handed over that the register would drop.
  assign i0_ready = rst_n & load & g0;
  assign i1_ready = rst_n & load & g1;
  assign acc0     = i0_valid & i0_ready;
  assign acc1     = i1_valid & i1_ready;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    if (acc0) begin
      y_data_d  = i0_data;
      y_last_d  = i0_last;
      y_valid_d = 1'b1;
      sel_d     = 1'b0;
      if (i0_last) begin
        state_d = StIdle;
        prio_d  = 1'b1;
      end else begin
        state_d = StLock0;
      end
    end else if (acc1) begin
      y_data_d  = i1_data;
      y_last_d  = i1_last;
      y_valid_d = 1'b1;
      sel_d     = 1'b1;
      if (i1_last) begin
        state_d = StIdle;
        prio_d  = 1'b0;
      end else begin
        state_d = StLock1;
      end
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_valid_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign y_valid = y_valid_q;
  assign sel     = sel_q;

endmodule
